// File: rtl/vbi_sequence_extractor.sv
// vbi_sequence_extractor
// Slices one VBI line of decoded luma into a 48-bit frame: preamble, 32-bit
// sequence number, then CRC-8. A good frame updates sequence_external and
// raises sequence_external_valid for VALID_HOLD clocks. A bad frame pulses
// frame_error and bumps a saturating error counter.
// Build option: define SEQ_CRC_CHECK_EN to require a CRC-8 match (poly 0x07,
// init 0x00) in addition to the preamble. Without it, the CRC byte is
// sampled but ignored.
module vbi_sequence_extractor #(
    parameter logic [9:0] SEQ_LINE        = 10'd14,
    parameter int         FIELD_SEL       = 2,
    parameter int         START_OFFSET    = 16,
    parameter int         SAMPLES_PER_BIT = 8,
    parameter logic [7:0] THRESHOLD       = 8'd128,
    parameter logic [7:0] PREAMBLE        = 8'hA5,
    parameter int         VALID_HOLD      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    input  logic [7:0]  luma,
    input  logic        line_start,
    input  logic [9:0]  line_number,
    input  logic        field,
    output logic [31:0] sequence_external,
    output logic        sequence_external_valid,
    output logic        frame_error,
    output logic [15:0] error_count
);

    typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, HOLD} state_t;

    // Pixel count of the centre of bit cell 0, and the spacing between cells.
    localparam logic [15:0] FIRST_SAMPLE = 16'(START_OFFSET + SAMPLES_PER_BIT / 2);
    localparam logic [15:0] BIT_STEP     = 16'(SAMPLES_PER_BIT);
    localparam logic [15:0] HOLD_LAST    = 16'(VALID_HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] pix_cnt;
    logic [15:0] sample_at;
    logic [5:0]  bit_cnt;
    logic [39:0] frame_shift;     // preamble in [39:32], sequence in [31:0]
    logic [15:0] hold_cnt;

    logic        line_match;
    logic        field_ok;
    logic        sliced_bit;
    logic        sample_hit;
    logic        frame_ok;

    logic        start_frame;
    logic        take_bit;
    logic        accept;
    logic        reject;

    assign field_ok   = (FIELD_SEL == 2) || (FIELD_SEL == 0 && !field) || (FIELD_SEL == 1 && field);
    assign line_match = line_start && (line_number == SEQ_LINE) && field_ok;
    assign sliced_bit = (luma >= THRESHOLD);
    assign sample_hit = pix_valid && (pix_cnt == sample_at);

`ifdef SEQ_CRC_CHECK_EN
    logic [7:0] crc_calc;
    logic [7:0] crc_rx;

    // One serial step of CRC-8, polynomial x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // CRC runs over the 32 sequence bits; the received CRC byte is collected separately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_calc <= 8'h00;
            crc_rx   <= 8'h00;
        end else if (start_frame) begin
            crc_calc <= 8'h00;
            crc_rx   <= 8'h00;
        end else if (take_bit) begin
            if (bit_cnt >= 6'd8 && bit_cnt <= 6'd39)
                crc_calc <= crc8_step(crc_calc, sliced_bit);
            if (bit_cnt >= 6'd40)
                crc_rx <= {crc_rx[6:0], sliced_bit};
        end
    end

    assign frame_ok = (frame_shift[39:32] == PREAMBLE) && (crc_calc == crc_rx);
`else
    assign frame_ok = (frame_shift[39:32] == PREAMBLE);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every register here uses <= so all flops update together on the edge.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and the one-cycle datapath controls.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next  = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        unique case (state)
            IDLE: begin
                if (line_match) begin
                    start_frame = 1'b1;
                    state_next  = SAMPLE;
                end
            end
            SAMPLE: begin
                if (line_start) begin
                    // A new line always kills the frame in flight; restart if it is ours.
                    reject = 1'b1;
                    if (line_match) start_frame = 1'b1;
                    else            state_next  = IDLE;
                end else if (sample_hit) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 6'd47) state_next = CHECK;
                end
            end
            CHECK: begin
                if (frame_ok) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end else begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (line_match) begin
                    start_frame = 1'b1;
                    state_next  = SAMPLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid drops in the same cycle a matching line_start arrives during HOLD.
    assign sequence_external_valid = (state == HOLD) && !line_match;
    assign frame_error             = reject;

    // Pixel counting and bit-cell sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt     <= 16'd0;
            sample_at   <= FIRST_SAMPLE;
            bit_cnt     <= 6'd0;
            frame_shift <= 40'd0;
        end else if (start_frame) begin
            pix_cnt     <= 16'd0;
            sample_at   <= FIRST_SAMPLE;
            bit_cnt     <= 6'd0;
            frame_shift <= 40'd0;
        end else begin
            if (pix_valid) pix_cnt <= pix_cnt + 16'd1;
            if (take_bit) begin
                sample_at <= sample_at + BIT_STEP;
                bit_cnt   <= bit_cnt + 6'd1;
                // Only preamble and sequence are kept; CRC bits are handled apart.
                if (bit_cnt < 6'd40) frame_shift <= {frame_shift[38:0], sliced_bit};
            end
        end
    end

    // Published sequence, hold timer and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sequence_external <= 32'd0;
            hold_cnt          <= 16'd0;
            error_count       <= 16'd0;
        end else begin
            if (accept) begin
                sequence_external <= frame_shift[31:0];
                hold_cnt          <= 16'd0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
            if (reject && error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
        end
    end

endmodule
